// File: rtl/aes_pkg.sv
// Shared AES types, per-mode key-schedule constants and GF(2^8) helpers.
package aes_pkg;

    typedef enum logic [1:0] {
        AES128 = 2'b00,
        AES192 = 2'b01,
        AES256 = 2'b10,
        RSVD   = 2'b11
    } aes_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXPAND = 2'b01,
        STREAM = 2'b10
    } ks_state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Key length in words.
    function automatic logic [5:0] nk_of(input aes_mode_e m);
        case (m)
            AES128:  nk_of = 6'd4;
            AES192:  nk_of = 6'd6;
            AES256:  nk_of = 6'd8;
            default: nk_of = 6'd4;
        endcase
    endfunction

    // Number of rounds.
    function automatic logic [3:0] nr_of(input aes_mode_e m);
        case (m)
            AES128:  nr_of = 4'd10;
            AES192:  nr_of = 4'd12;
            AES256:  nr_of = 4'd14;
            default: nr_of = 4'd10;
        endcase
    endfunction

    // Total expanded words, 4*(Nr+1).
    function automatic logic [5:0] nw_of(input aes_mode_e m);
        case (m)
            AES128:  nw_of = 6'd44;
            AES192:  nw_of = 6'd52;
            AES256:  nw_of = 6'd60;
            default: nw_of = 6'd44;
        endcase
    endfunction

    // Multiply by x modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply, shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ aa;
            end else begin
                acc = acc;
            end
            aa = xtime(aa);
        end
        gf_mul = acc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse (x^254) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    logic [7:0] p2_s, p4_s, p8_s, p16_s, p32_s, p64_s, p128_s;
    logic [7:0] inv_s;

    assign p2_s   = gf_mul(in_i, in_i);
    assign p4_s   = gf_mul(p2_s, p2_s);
    assign p8_s   = gf_mul(p4_s, p4_s);
    assign p16_s  = gf_mul(p8_s, p8_s);
    assign p32_s  = gf_mul(p16_s, p16_s);
    assign p64_s  = gf_mul(p32_s, p32_s);
    assign p128_s = gf_mul(p64_s, p64_s);

    // Inverse as product of x^2..x^128 (exponent 254); zero maps to zero.
    always_comb begin
        inv_s = gf_mul(gf_mul(gf_mul(p2_s, p4_s), gf_mul(p8_s, p16_s)),
                       gf_mul(gf_mul(p32_s, p64_s), p128_s));
    end

    // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    always_comb begin
        out_o = inv_s
              ^ {inv_s[6:0], inv_s[7]}
              ^ {inv_s[5:0], inv_s[7:6]}
              ^ {inv_s[4:0], inv_s[7:5]}
              ^ {inv_s[3:0], inv_s[7:4]}
              ^ 8'h63;
    end

endmodule

// File: rtl/aes_subword.sv
// SubWord: S-box applied to each byte of a 32-bit word.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    for (genvar g = 0; g < 4; g++) begin : g_byte
        aes_sbox u_sbox (
            .in_i  (word_i[8*g +: 8]),
            .out_o (word_o[8*g +: 8])
        );
    end

endmodule

// File: rtl/aes_dec_key_sched.sv
// Sequential AES key expander streaming round keys in decryption order (Nr..0).
module aes_dec_key_sched
    import aes_pkg::*;
#(
    parameter int NW = 60
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         cfg_err,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_last
);

    ks_state_e    state_q, state_d;
    aes_mode_e    mode_q, mode_d;
    logic [5:0]   idx_q, idx_d;
    logic [2:0]   wrap_q, wrap_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic         busy_q, busy_d;
    logic         cfg_err_q, cfg_err_d;
    logic         rk_valid_q, rk_valid_d;
    logic [127:0] rk_out_q, rk_out_d;
    logic [3:0]   rk_round_q, rk_round_d;
    logic         rk_last_q, rk_last_d;
    logic [31:0]  ks_q [NW];

    logic [5:0]   nk_s, nw_s;
    logic [3:0]   nr_s;
    logic [5:0]   prev_idx_s, back_idx_s, nxt_base_s;
    logic [31:0]  prev_s, back_s, sub_in_s, sub_out_s, new_word_s;
    logic         load_s, wr_en_s;

    assign nk_s = nk_of(mode_q);
    assign nr_s = nr_of(mode_q);
    assign nw_s = nw_of(mode_q);

    // Read addresses for the recurrence and for the next streamed round key.
    always_comb begin
        prev_idx_s = 6'd0;
        back_idx_s = 6'd0;
        nxt_base_s = 6'd0;
        if (state_q == EXPAND) begin
            prev_idx_s = idx_q - 6'd1;
            back_idx_s = idx_q - nk_s;
        end else begin
            prev_idx_s = 6'd0;
        end
        if (round_q != 4'd0) begin
            nxt_base_s = {round_q - 4'd1, 2'b00};
        end else begin
            nxt_base_s = 6'd0;
        end
    end

    assign prev_s = ks_q[prev_idx_s];
    assign back_s = ks_q[back_idx_s];

    // One SubWord shared by the RotWord and the AES-256 mid-block cases.
    assign sub_in_s = (wrap_q == 3'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s;

    aes_subword u_subword (
        .word_i (sub_in_s),
        .word_o (sub_out_s)
    );

    // Next expanded word w[i] = w[i-Nk] ^ t.
    always_comb begin
        new_word_s = back_s ^ prev_s;
        if (wrap_q == 3'd0) begin
            new_word_s = back_s ^ sub_out_s ^ {rcon_q, 24'h000000};
        end else if ((nk_s == 6'd8) && (wrap_q == 3'd4)) begin
            new_word_s = back_s ^ sub_out_s;
        end else begin
            new_word_s = back_s ^ prev_s;
        end
    end

    // Control FSM next-state and registered-output next values.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        idx_d      = idx_q;
        wrap_d     = wrap_q;
        rcon_d     = rcon_q;
        round_d    = round_q;
        busy_d     = busy_q;
        cfg_err_d  = 1'b0;
        rk_valid_d = rk_valid_q;
        rk_out_d   = rk_out_q;
        rk_round_d = rk_round_q;
        rk_last_d  = rk_last_q;
        load_s     = 1'b0;
        wr_en_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (aes_mode_e'(mode) == RSVD) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        load_s  = 1'b1;
                        mode_d  = aes_mode_e'(mode);
                        idx_d   = nk_of(aes_mode_e'(mode));
                        wrap_d  = 3'd0;
                        rcon_d  = RCON_INIT;
                        busy_d  = 1'b1;
                        state_d = EXPAND;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXPAND: begin
                wr_en_s = 1'b1;
                idx_d   = idx_q + 6'd1;
                wrap_d  = (wrap_q == (nk_s[2:0] - 3'd1)) ? 3'd0 : (wrap_q + 3'd1);
                if (wrap_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end else begin
                    rcon_d = rcon_q;
                end
                if (idx_q == (nw_s - 6'd1)) begin
                    // Last word is bypassed straight into the first round key.
                    state_d    = STREAM;
                    round_d    = nr_s;
                    rk_valid_d = 1'b1;
                    rk_round_d = nr_s;
                    rk_last_d  = 1'b0;
                    rk_out_d   = {ks_q[nw_s - 6'd4], ks_q[nw_s - 6'd3],
                                  ks_q[nw_s - 6'd2], new_word_s};
                end else begin
                    state_d = EXPAND;
                end
            end
            STREAM: begin
                if (rk_valid_q && rk_ready) begin
                    if (round_q == 4'd0) begin
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        idx_d      = 6'd0;
                        wrap_d     = 3'd0;
                        rk_valid_d = 1'b0;
                        rk_out_d   = 128'd0;
                        rk_round_d = 4'd0;
                        rk_last_d  = 1'b0;
                    end else begin
                        round_d    = round_q - 4'd1;
                        rk_round_d = round_q - 4'd1;
                        rk_last_d  = (round_q == 4'd1);
                        rk_out_d   = {ks_q[nxt_base_s], ks_q[nxt_base_s + 6'd1],
                                      ks_q[nxt_base_s + 6'd2], ks_q[nxt_base_s + 6'd3]};
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            default: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                rk_valid_d = 1'b0;
                rk_out_d   = 128'd0;
                rk_round_d = 4'd0;
                rk_last_d  = 1'b0;
            end
        endcase
    end

    // Control and output registers; reset aborts any job immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= AES128;
            idx_q      <= 6'd0;
            wrap_q     <= 3'd0;
            rcon_q     <= RCON_INIT;
            round_q    <= 4'd0;
            busy_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_out_q   <= 128'd0;
            rk_round_q <= 4'd0;
            rk_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            idx_q      <= idx_d;
            wrap_q     <= wrap_d;
            rcon_q     <= rcon_d;
            round_q    <= round_d;
            busy_q     <= busy_d;
            cfg_err_q  <= cfg_err_d;
            rk_valid_q <= rk_valid_d;
            rk_out_q   <= rk_out_d;
            rk_round_q <= rk_round_d;
            rk_last_q  <= rk_last_d;
        end
    end

    // Key store: cipher key on accept, then one expanded word per EXPAND cycle.
    always_ff @(posedge clk) begin
        if (load_s) begin
            for (int j = 0; j < 8; j++) begin
                ks_q[j] <= key_in[255 - 32*j -: 32];
            end
        end else if (wr_en_s) begin
            ks_q[idx_q] <= new_word_s;
        end
    end

    assign busy     = busy_q;
    assign cfg_err  = cfg_err_q;
    assign rk_valid = rk_valid_q;
    assign rk_out   = rk_out_q;
    assign rk_round = rk_round_q;
    assign rk_last  = rk_last_q;

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Scoreboard bench for aes_dec_key_sched: table-driven reference expansion plus FIPS-197 vectors.
module tb_aes_dec_key_sched;

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   round;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [255:0] key_in = 256'd0;
    logic         busy, cfg_err, rk_valid, rk_last;
    logic         rk_ready = 1'b1;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   exp_first_cyc = -1;
    int   xfers = 0;
    logic rdy_rand = 1'b0;
    exp_t sb_q[$];
    logic [31:0] mw [60];

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'd0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic [127:0] sbox_rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    logic [7:0] rcon_tbl [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    aes_dec_key_sched #(.NW(60)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .key_in   (key_in),
        .busy     (busy),
        .cfg_err  (cfg_err),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .rk_last  (rk_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: always ready, or randomly stalling when rdy_rand is set.
    always @(posedge clk) begin
        #1;
        if (rdy_rand) rk_ready = 1'($urandom_range(0, 1));
        else          rk_ready = 1'b1;
    end

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] b);
        logic [127:0] row;
        row = sbox_rows[b[7:4]];
        return row[127 - 8*b[3:0] -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    task automatic model_expand(input logic [1:0] m, input logic [255:0] k);
        int nk, nw;
        logic [31:0] t;
        nk = (m == 2'd0) ? 4 : ((m == 2'd1) ? 6 : 8);
        nw = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = mw[i-1];
            if (i % nk == 0)                t = subw({t[23:0], t[31:24]}) ^ {rcon_tbl[i/nk], 24'h0};
            else if (nk == 8 && i % 8 == 4) t = subw(t);
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard monitor: compare presented key to queue head, pop on handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (rk_valid) begin
                if (exp_first_cyc >= 0) begin
                    chk("first_valid_cycle", 160'(cyc), 160'(exp_first_cyc));
                    exp_first_cyc = -1;
                end
                if (sb_q.size() == 0) begin
                    chk("unexpected_rk_valid", 160'(rk_valid), 160'(0));
                end else begin
                    chk("rk_out", 160'(rk_out), 160'(sb_q[0].key));
                    chk("rk_round", 160'(rk_round), 160'(sb_q[0].round));
                    chk("rk_last", 160'(rk_last), 160'(sb_q[0].last));
                    if (rk_ready) begin
                        void'(sb_q.pop_front());
                        xfers++;
                    end
                end
            end else begin
                chk("idle_outputs_zero", 160'({rk_out, rk_round, rk_last}), 160'(0));
                if (exp_first_cyc >= 0 && cyc >= exp_first_cyc) begin
                    chk("first_valid_late", 160'(cyc), 160'(exp_first_cyc));
                    exp_first_cyc = -1;
                end
            end
        end
    end

    task automatic start_job(input logic [1:0] m, input logic [255:0] k);
        int nk, nr;
        nk = (m == 2'd0) ? 4 : ((m == 2'd1) ? 6 : 8);
        nr = nk + 6;
        model_expand(m, k);
        for (int r = nr; r >= 0; r--) begin
            sb_q.push_back({mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3], 4'(r), (r == 0)});
        end
        @(posedge clk); #1;
        start = 1'b1; mode = m; key_in = k; xfers = 0;
        exp_first_cyc = cyc + 1 + 4*(nr+1) - nk;
        @(posedge clk); #1;
        start = 1'b0; mode = 2'($urandom_range(0, 3)); key_in = rand_key();
        chk("busy_after_start", 160'(busy), 160'(1));
    endtask

    task automatic wait_done(input int budget, input int exp_xfers);
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("job_done", 160'(sb_q.size() == 0 && !busy), 160'(1));
        chk("transfers", 160'(xfers), 160'(exp_xfers));
        chk("rk_valid_after_done", 160'(rk_valid), 160'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("reset_outputs_zero", 160'({busy, cfg_err, rk_valid, rk_out, rk_round, rk_last}), 160'(0));
        sb_q.delete();
        exp_first_cyc = -1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Watchdog so the run cannot hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int n;
        logic found;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 160'({busy, cfg_err, rk_valid, rk_out, rk_round, rk_last}), 160'(0));
        reset = 1'b0;

        // AES-128 FIPS-197 key with hand vectors at r=10, r=1 and r=0.
        start_job(2'b00, K128);
        sb_q[0].key  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        sb_q[9].key  = 128'ha0fafe1788542cb123a339392a6c7605;
        sb_q[10].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        wait_done(200, 11);

        // AES-192 with ignored starts during EXPAND and STREAM.
        start_job(2'b01, K192);
        sb_q[0].key = 128'he98ba06f448c773c8ecc720401002202;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; mode = 2'b00; key_in = rand_key();
        @(posedge clk); #1;
        start = 1'b1; mode = 2'b11;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ignored_start_busy", 160'(busy), 160'(1));
        @(posedge clk); #1;
        chk("ignored_rsvd_no_cfg_err", 160'(cfg_err), 160'(0));
        n = 0;
        while (!rk_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("a192_reached_stream", 160'(rk_valid), 160'(1));
        start = 1'b1; mode = 2'b10; key_in = rand_key();
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("stream_start_no_cfg_err", 160'(cfg_err), 160'(0));
        wait_done(200, 13);

        // AES-256 with hand vectors at r=14 and r=0.
        start_job(2'b10, K256);
        sb_q[0].key  = 128'hfe4890d1e6188d0b046df344706c631e;
        sb_q[14].key = 128'h603deb1015ca71be2b73aef0857d7781;
        wait_done(200, 15);

        // Random backpressure on all three key sizes with random keys.
        rdy_rand = 1'b1;
        for (int m = 0; m < 3; m++) begin
            start_job(2'(m), rand_key());
            wait_done(600, 11 + 2*m);
        end
        rdy_rand = 1'b0;

        // Reserved mode: one-cycle cfg_err, never busy.
        @(posedge clk); #1;
        start = 1'b1; mode = 2'b11; key_in = rand_key();
        @(posedge clk); #1;
        start = 1'b0;
        chk("cfg_err_pulse", 160'({cfg_err, busy}), 160'(2'b10));
        @(posedge clk); #1;
        chk("cfg_err_clears", 160'({cfg_err, busy}), 160'(2'b00));

        // Reset in the middle of EXPAND (cycle T+20), then a clean job.
        start_job(2'b00, rand_key());
        repeat (19) @(posedge clk);
        #1;
        chk("mid_expand_busy", 160'({busy, rk_valid}), 160'(2'b10));
        do_reset();
        repeat (60) @(posedge clk);
        #1;
        chk("no_output_after_expand_reset", 160'({busy, rk_valid}), 160'(0));
        start_job(2'b00, rand_key());
        wait_done(200, 11);

        // Reset in the middle of STREAM at r=5, then the FIPS AES-128 job again.
        start_job(2'b00, K128);
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            @(posedge clk); #1;
            found = rk_valid && (rk_round == 4'd5);
            n++;
        end
        chk("reached_r5", 160'(found), 160'(1));
        do_reset();
        repeat (30) @(posedge clk);
        #1;
        chk("no_output_after_stream_reset", 160'({busy, rk_valid}), 160'(0));
        start_job(2'b00, K128);
        sb_q[0].key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        sb_q[9].key = 128'ha0fafe1788542cb123a339392a6c7605;
        wait_done(200, 11);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
